instr_align_stage: RTL and testbench
====================================

INSTR_ALIGN_STAGE -- requirements
Module: instr_align_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port jmp_req  input  1  redirect from execute; shared with the ibus interface.
REQ-005 SHALL have port jmp_addr  input  32  redirect target, 2-aligned; bit 0 ignored.
REQ-006 SHALL have port instr_vld_size  input  2  halfwords available: 00 none, 01 16 bits, 1x 32 bits.
REQ-007 SHALL have port instr  input  32  head of the fetch queue; low halfword is the oldest.
REQ-008 SHALL have port instr_has_fault  input  1  head data came from a faulted bus access.
REQ-009 SHALL have port instr_fetch  output  1  pop request to the fetch queue.
REQ-010 SHALL have port instr_fetch_size  output  2  pop size: 01 pops 16 bits, 10 pops 32 bits.
REQ-011 SHALL have port out_vld  output  1  decode-stage entry valid.
REQ-012 SHALL have port out_rdy  input  1  decode stage accepts the entry.
REQ-013 SHALL have port out_instr  output  32  aligned instruction; bits 31:16 are zero for 16-bit instructions.
REQ-014 SHALL have port out_pc  output  32  address of out_instr.
REQ-015 SHALL have port out_is_16bit  output  1  compressed instruction flag.
REQ-016 SHALL have port out_fault  output  1  instruction fetch access fault.

Function
REQ-017 SHALL decode length combinationally: instr[1:0]!=2'b11 means 16-bit; otherwise 32-bit.
REQ-018 SHALL treat the head as available when the length is 16-bit and instr_vld_size!=00, or the length is 32-bit and instr_vld_size[1]=1.
REQ-019 SHALL have a two-state FSM: RUN and HALT.
REQ-020 SHALL define slot_free = ~out_vld | out_rdy.
REQ-021 SHALL define take = RUN & ~jmp_req & slot_free & (instr_has_fault ? instr_vld_size!=00 : available).
REQ-022 SHALL drive instr_fetch = take & ~instr_has_fault, with instr_fetch_size = 01 for 16-bit and 10 for 32-bit.
REQ-023 SHALL drive instr_fetch_size to 00 when instr_fetch=0.
REQ-024 SHALL, on a non-fault take, register out_instr, out_pc=pc, out_is_16bit and out_fault=0, set out_vld=1, and advance pc by 2 or 4 with 32-bit wrap (32'hFFFF_FFFE+2 gives 0).
REQ-025 SHALL, on a fault take, register out_instr=instr, out_pc=pc, out_is_16bit=1 and out_fault=1, set out_vld=1, leave pc unchanged, pop nothing, and move to HALT.
REQ-026 SHALL, in HALT, issue no take or instr_fetch until jmp_req.
REQ-027 SHALL clear out_vld when out_vld & out_rdy & ~take, and keep the entry valid on back-to-back takes.
REQ-028 SHALL hold all out_* stable while out_vld & ~out_rdy.
REQ-029 SHALL, on jmp_req, set pc={jmp_addr[31:1],0}, clear out_vld, enter RUN and suppress take and instr_fetch in that cycle; jmp_req has priority over every other event.
REQ-030 SHALL give one-cycle latency from an available head and free slot to out_vld=1.
REQ-031 SHALL sustain one instruction per cycle when out_rdy=1 and the head is continuously available.
REQ-032 SHALL wait, with no pop, when the head is a 32-bit instruction and instr_vld_size=01 (split instruction).

Reset
REQ-033 SHALL, on rstn=0 at a clock edge, set pc=RESET_PC, state=RUN, out_vld=0, out_instr=0, out_pc=0, out_is_16bit=0 and out_fault=0.
REQ-034 SHALL give rstn priority over jmp_req and take, and discard any in-flight output entry when reset is asserted mid-operation.
REQ-035 SHALL not assert instr_fetch in any cycle in which rstn=0.

Verification
REQ-036 SHALL cover: after reset, instr=32'h0000_4501, vld=01, out_rdy=1 -> next cycle out_vld=1, out_pc=RESET_PC, out_instr=32'h0000_4501, out_is_16bit=1; instr_fetch=1 with size 01 in the take cycle.
REQ-037 SHALL cover: head 32'h0010_0093 with vld=01 for 3 cycles, then vld=10 -> no pop during the 3 cycles; then pop size 10, out_instr=32'h0010_0093, pc advanced by 4.
REQ-038 SHALL cover: out_vld=1, out_rdy=0 for 4 cycles with the head available -> out_* unchanged and instr_fetch=0; out_rdy=1 -> new take in the same cycle.
REQ-039 SHALL cover: jmp_req with jmp_addr=32'h0000_0103 while out_vld=1 -> next cycle out_vld=0, pc=32'h0000_0102; the first following take yields out_pc=32'h0000_0102.
REQ-040 SHALL cover: instr_has_fault=1 with vld=01 -> out_fault=1, out_vld=1, FSM in HALT, instr_fetch stays 0 with heads available; jmp_req returns the FSM to RUN.
REQ-041 SHALL cover: pc=32'hFFFF_FFFE with a 16-bit take -> out_pc=32'hFFFF_FFFE; the next out_pc=0.

Source files
------------

// File: rtl/instr_align_stage.sv
// Instruction align stage: decodes 16/32-bit length at the head of the fetch
// queue, pops it and presents one aligned instruction per cycle to decode.
module instr_align_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jmp_req,
  input  logic [31:0] jmp_addr,
  input  logic [1:0]  instr_vld_size,
  input  logic [31:0] instr,
  input  logic        instr_has_fault,
  output logic        instr_fetch,
  output logic [1:0]  instr_fetch_size,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_16bit,
  output logic        out_fault
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  function automatic logic is_16bit_len(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

  function automatic logic [31:0] align_instr(input logic [31:0] raw, input logic is16);
    return is16 ? {16'h0000, raw[15:0]} : raw;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_p0;
  logic        head_is_16;
  logic        head_avail;
  logic        slot_free;
  logic        take;
  logic [31:0] jmp_target;

  // bit 0 of the redirect target is dropped: targets are halfword aligned
  assign jmp_target = jmp_addr & ~32'd1;

  always_comb begin
    state_d          = state_q;
    take             = 1'b0;
    instr_fetch      = 1'b0;
    instr_fetch_size = 2'b00;
    head_is_16       = is_16bit_len(instr[1:0]);
    head_avail       = head_is_16 ? (instr_vld_size != 2'b00) : instr_vld_size[1];
    slot_free        = ~out_vld | out_rdy;
    // a faulted head is consumed as soon as anything is present; it is never popped
    if (rstn && (state_q == ST_RUN) && !jmp_req && slot_free &&
        (instr_has_fault ? (instr_vld_size != 2'b00) : head_avail))
      take = 1'b1;
    if (take && !instr_has_fault) begin
      instr_fetch      = 1'b1;
      instr_fetch_size = head_is_16 ? 2'b01 : 2'b10;
    end
    if (jmp_req)
      state_d = ST_RUN;
    else if (take && instr_has_fault)
      state_d = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  // p0: decode-stage entry register and program counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_p0        <= RESET_PC;
      out_vld      <= 1'b0;
      out_instr    <= 32'h0;
      out_pc       <= 32'h0;
      out_is_16bit <= 1'b0;
      out_fault    <= 1'b0;
    end else if (jmp_req) begin
      pc_p0   <= jmp_target;
      out_vld <= 1'b0;
    end else if (take) begin
      out_vld <= 1'b1;
      out_pc  <= pc_p0;
      if (instr_has_fault) begin
        out_instr    <= instr;
        out_is_16bit <= 1'b1;
        out_fault    <= 1'b1;
      end else begin
        out_instr    <= align_instr(instr, head_is_16);
        out_is_16bit <= head_is_16;
        out_fault    <= 1'b0;
        pc_p0        <= pc_p0 + (head_is_16 ? 32'd2 : 32'd4);
      end
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_align_stage.sv
// Bench for instr_align_stage: directed scenarios plus a randomized halfword
// stream checked against an in-order program image.
module tb_instr_align_stage;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jmp_req;
  logic [31:0] jmp_addr;
  logic [1:0]  instr_vld_size;
  logic [31:0] instr;
  logic        instr_has_fault;
  logic        instr_fetch;
  logic [1:0]  instr_fetch_size;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_16bit;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_align_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .jmp_req(jmp_req), .jmp_addr(jmp_addr),
    .instr_vld_size(instr_vld_size), .instr(instr), .instr_has_fault(instr_has_fault),
    .instr_fetch(instr_fetch), .instr_fetch_size(instr_fetch_size),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_instr(out_instr), .out_pc(out_pc),
    .out_is_16bit(out_is_16bit), .out_fault(out_fault)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; jmp_req = 1'b1; jmp_addr = 32'h40; instr = 32'h0000_4501;
    instr_vld_size = 2'b10; instr_has_fault = 1'b0; out_rdy = 1'b1;
    #1;
    checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b want 0", instr_fetch); end
    cyc();
    cyc();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", out_vld); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    checks++; if ({out_is_16bit, out_fault} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {out_is_16bit, out_fault}); end
  endtask

  task automatic test_first_take();
    rstn = 1'b1; jmp_req = 1'b0; instr = 32'h0000_4501; instr_vld_size = 2'b01; out_rdy = 1'b1;
    #1;
    checks++; if ({instr_fetch, instr_fetch_size} !== 3'b101) begin errors++; $display("FAIL first_fetch: got %b want 101", {instr_fetch, instr_fetch_size}); end
    cyc();
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL first_vld: got %b want 1", out_vld); end
    checks++; if (out_pc !== RST_PC) begin errors++; $display("FAIL first_pc: got %h want %h", out_pc, RST_PC); end
    checks++; if (out_instr !== 32'h0000_4501) begin errors++; $display("FAIL first_instr: got %h want 00004501", out_instr); end
    checks++; if (out_is_16bit !== 1'b1) begin errors++; $display("FAIL first_is16: got %b want 1", out_is_16bit); end
  endtask

  task automatic test_split_32();
    instr = 32'h0010_0093; instr_vld_size = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL split_nopop%0d: got %b want 0", i, instr_fetch); end
      cyc();
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL split_drained: got %b want 0", out_vld); end
    instr_vld_size = 2'b10;
    #1;
    checks++; if ({instr_fetch, instr_fetch_size} !== 3'b110) begin errors++; $display("FAIL split_pop: got %b want 110", {instr_fetch, instr_fetch_size}); end
    cyc();
    checks++; if (out_instr !== 32'h0010_0093) begin errors++; $display("FAIL split_instr: got %h want 00100093", out_instr); end
    checks++; if (out_pc !== RST_PC + 32'd2) begin errors++; $display("FAIL split_pc: got %h want %h", out_pc, RST_PC + 32'd2); end
    checks++; if (out_is_16bit !== 1'b0) begin errors++; $display("FAIL split_is16: got %b want 0", out_is_16bit); end
    instr = 32'hFFFF_4501; instr_vld_size = 2'b01;
    cyc();
    checks++; if (out_pc !== RST_PC + 32'd6) begin errors++; $display("FAIL split_next_pc: got %h want %h", out_pc, RST_PC + 32'd6); end
    checks++; if (out_instr !== 32'h0000_4501) begin errors++; $display("FAIL split_zero_hi: got %h want 00004501", out_instr); end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0; instr = 32'h0000_4502; instr_vld_size = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL bp_fetch%0d: got %b want 0", i, instr_fetch); end
      cyc();
      checks++; if ({out_vld, out_pc, out_instr} !== {1'b1, RST_PC + 32'd6, 32'h0000_4501}) begin
        errors++; $display("FAIL bp_hold%0d: got %b/%h/%h want 1/%h/00004501", i, out_vld, out_pc, out_instr, RST_PC + 32'd6);
      end
    end
    out_rdy = 1'b1;
    #1;
    checks++; if ({instr_fetch, instr_fetch_size} !== 3'b101) begin errors++; $display("FAIL bp_release: got %b want 101", {instr_fetch, instr_fetch_size}); end
    cyc();
    checks++; if (out_pc !== RST_PC + 32'd8) begin errors++; $display("FAIL bp_pc: got %h want %h", out_pc, RST_PC + 32'd8); end
    checks++; if (out_instr !== 32'h0000_4502) begin errors++; $display("FAIL bp_instr: got %h want 00004502", out_instr); end
  endtask

  task automatic test_jump();
    out_rdy = 1'b0; jmp_req = 1'b1; jmp_addr = 32'h0000_0103; instr = 32'h0000_4501; instr_vld_size = 2'b10;
    #1;
    checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL jmp_fetch: got %b want 0", instr_fetch); end
    cyc();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL jmp_vld: got %b want 0", out_vld); end
    jmp_req = 1'b0; out_rdy = 1'b1;
    #1;
    checks++; if (instr_fetch !== 1'b1) begin errors++; $display("FAIL jmp_take: got %b want 1", instr_fetch); end
    cyc();
    checks++; if (out_pc !== 32'h0000_0102) begin errors++; $display("FAIL jmp_pc: got %h want 00000102", out_pc); end
  endtask

  task automatic test_fault();
    instr = 32'hDEAD_BEEF; instr_has_fault = 1'b1; instr_vld_size = 2'b01; out_rdy = 1'b1;
    #1;
    checks++; if ({instr_fetch, instr_fetch_size} !== 3'b000) begin errors++; $display("FAIL fault_nopop: got %b want 000", {instr_fetch, instr_fetch_size}); end
    cyc();
    checks++; if ({out_vld, out_fault, out_is_16bit} !== 3'b111) begin errors++; $display("FAIL fault_flags: got %b want 111", {out_vld, out_fault, out_is_16bit}); end
    checks++; if (out_pc !== 32'h0000_0104) begin errors++; $display("FAIL fault_pc: got %h want 00000104", out_pc); end
    checks++; if (out_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fault_instr: got %h want deadbeef", out_instr); end
    instr_has_fault = 1'b0; instr = 32'h0000_4501; instr_vld_size = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL halt_fetch%0d: got %b want 0", i, instr_fetch); end
      cyc();
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL halt_vld: got %b want 0", out_vld); end
    jmp_req = 1'b1; jmp_addr = 32'h0000_0200;
    cyc();
    jmp_req = 1'b0;
    #1;
    checks++; if (instr_fetch !== 1'b1) begin errors++; $display("FAIL halt_exit: got %b want 1", instr_fetch); end
    cyc();
    checks++; if ({out_pc, out_fault} !== {32'h0000_0200, 1'b0}) begin errors++; $display("FAIL halt_exit_pc: got %h/%b want 00000200/0", out_pc, out_fault); end
  endtask

  task automatic test_pc_wrap();
    jmp_req = 1'b1; jmp_addr = 32'hFFFF_FFFE; instr_vld_size = 2'b00;
    cyc();
    jmp_req = 1'b0; instr = 32'h0000_4501; instr_vld_size = 2'b01; out_rdy = 1'b1;
    cyc();
    checks++; if (out_pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_pc0: got %h want fffffffe", out_pc); end
    instr = 32'h0000_4505;
    cyc();
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h want 00000000", out_pc); end
    instr_vld_size = 2'b00;
    cyc();
  endtask

  task automatic test_reset_midop();
    instr = 32'h0000_4501; instr_vld_size = 2'b01; out_rdy = 1'b0;
    cyc();
    rstn = 1'b0; jmp_req = 1'b1; jmp_addr = 32'h0000_0300;
    #1;
    checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL midrst_fetch: got %b want 0", instr_fetch); end
    cyc();
    checks++; if ({out_vld, out_pc} !== {1'b0, 32'h0}) begin errors++; $display("FAIL midrst_clear: got %b/%h want 0/00000000", out_vld, out_pc); end
    rstn = 1'b1; jmp_req = 1'b0; out_rdy = 1'b1;
    cyc();
    checks++; if ({out_vld, out_pc} !== {1'b1, RST_PC}) begin errors++; $display("FAIL midrst_pc: got %b/%h want 1/%h", out_vld, out_pc, RST_PC); end
    instr_vld_size = 2'b00;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_pc[$];
    logic        exp_is16[$];
    logic [31:0] base, rnd;
    logic [15:0] lo, hi;
    int h, nacc, cycles, r, off;
    logic model_vld, head16, avail, exp_fetch;

    rnd = $urandom();
    base = {rnd[31:1], 1'b0};
    off = 0;
    for (int i = 0; i < 80; i++) begin
      lo = 16'($urandom());
      if ($urandom_range(1, 0) == 1) begin
        lo[1:0] = 2'($urandom_range(2, 0));
        prog.push_back(lo);
        exp_instr.push_back({16'h0000, lo}); exp_pc.push_back(base + 32'(2 * off)); exp_is16.push_back(1'b1);
        off += 1;
      end else begin
        lo[1:0] = 2'b11; hi = 16'($urandom());
        prog.push_back(lo); prog.push_back(hi);
        exp_instr.push_back({hi, lo}); exp_pc.push_back(base + 32'(2 * off)); exp_is16.push_back(1'b0);
        off += 2;
      end
    end

    jmp_req = 1'b1; jmp_addr = base | 32'($urandom_range(1, 0)); instr_vld_size = 2'b00;
    cyc();
    jmp_req = 1'b0;
    h = 0; nacc = 0; cycles = 0; model_vld = 1'b0;
    while (nacc < exp_instr.size() && cycles < 3000) begin
      r = $urandom_range(2, 0);
      if (r > prog.size() - h) r = prog.size() - h;
      rnd = $urandom();
      lo = (h < prog.size()) ? prog[h] : rnd[15:0];
      hi = (r == 2) ? prog[h + 1] : rnd[31:16];
      instr = {hi, lo};
      instr_vld_size = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : {1'b1, rnd[0]};
      out_rdy = ($urandom_range(3, 0) != 0);
      #1;
      head16 = (lo[1:0] != 2'b11);
      avail = (h < prog.size()) && (head16 ? (r >= 1) : (r == 2));
      exp_fetch = avail && (!model_vld || out_rdy);
      checks++; if (instr_fetch !== exp_fetch) begin errors++; $display("FAIL rand_fetch@%0d: got %b want %b", cycles, instr_fetch, exp_fetch); end
      if (exp_fetch) begin
        checks++; if (instr_fetch_size !== (head16 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rand_size@%0d: got %b want %b", cycles, instr_fetch_size, head16 ? 2'b01 : 2'b10); end
      end
      checks++; if (out_vld !== model_vld) begin errors++; $display("FAIL rand_vld@%0d: got %b want %b", cycles, out_vld, model_vld); end
      if (model_vld && out_rdy) begin
        checks++;
        if ({out_instr, out_pc, out_is_16bit, out_fault} !== {exp_instr[nacc], exp_pc[nacc], exp_is16[nacc], 1'b0}) begin
          errors++; $display("FAIL rand_entry%0d: got %h/%h/%b/%b want %h/%h/%b/0", nacc, out_instr, out_pc, out_is_16bit, out_fault, exp_instr[nacc], exp_pc[nacc], exp_is16[nacc]);
        end
        nacc++;
      end
      cyc();
      if (exp_fetch) begin
        h += head16 ? 1 : 2;
        model_vld = 1'b1;
      end else if (out_rdy) begin
        model_vld = 1'b0;
      end
      cycles++;
    end
    checks++; if (nacc != exp_instr.size()) begin errors++; $display("FAIL rand_timeout: got %0d entries want %0d", nacc, exp_instr.size()); end
    instr_vld_size = 2'b00; out_rdy = 1'b1;
    cyc();

    // full-rate streaming: a continuously available 16-bit head pops every cycle
    instr = 32'h0000_4501; instr_vld_size = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (instr_fetch !== 1'b1) begin errors++; $display("FAIL stream_fetch%0d: got %b want 1", i, instr_fetch); end
      cyc();
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL stream_vld%0d: got %b want 1", i, out_vld); end
    end
    instr_vld_size = 2'b00;
    cyc();
  endtask

  initial begin
    test_reset();
    test_first_take();
    test_split_32();
    test_backpressure();
    test_jump();
    test_fault();
    test_pc_wrap();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
